// File: rtl/cam_init_sequencer.sv
// ---------------------------------------------------------------------------
// cam_init_sequencer
//
// Power-up and configuration sequencer for an OV7670 camera. Walks the camera
// PWDN / RESET# pins through timed phases, fires a single-cycle start into
// cam_config, then waits for cam_config's done level to rise. A config timeout
// triggers a full power cycle and another attempt, up to MAX_RETRIES extra
// attempts, after which the block parks in an error state with the camera
// powered down. cam_ready gates the downstream capture / VGA path.
//
// Ports
//   clk               system clock
//   rst               synchronous reset, active-high
//   init_req          1-cycle request to (re)run the full sequence
//   done_cam_config   completion level from cam_config (rising edge counts)
//   start_cam_config  1-cycle start pulse to cam_config
//   cam_pwdn          camera PWDN pin (1 = powered down)
//   cam_rstn          camera RESET# pin (0 = held in reset)
//   init_busy         sequence in progress (power-down through config wait)
//   cam_ready         camera configured and usable
//   init_error        configuration failed on every attempt
//   retry_cnt         failed config attempts in the current sequence
//
// All outputs come straight from flops; each one is a decode of the next
// state, registered alongside the state itself.
// ---------------------------------------------------------------------------
module cam_init_sequencer #(
    parameter int PWDN_CYCLES    = 1000,
    parameter int RST_LOW_CYCLES = 1000,
    parameter int SETTLE_CYCLES  = 50000,
    parameter int CFG_TIMEOUT    = 2**22,
    parameter int MAX_RETRIES    = 3,
    parameter int AUTO_START     = 1,
    parameter int CNT_W          = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_req,
    input  logic       done_cam_config,
    output logic       start_cam_config,
    output logic       cam_pwdn,
    output logic       cam_rstn,
    output logic       init_busy,
    output logic       cam_ready,
    output logic       init_error,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWDN,
        S_RESET,
        S_SETTLE,
        S_START,
        S_WAIT_CFG,
        S_READY,
        S_ERROR
    } state_t;

    // Timer is loaded with N-1 on entry and the state exits when it reads 0,
    // so every timed state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] PWDN_LOAD   = CNT_W'(PWDN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CFG_LOAD    = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
    localparam logic [3:0]       MAX_RETRY   = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       retry_q, retry_d;
    logic             done_dly_q;

    logic             start_q, start_d;
    logic             pwdn_q, pwdn_d;
    logic             rstn_q, rstn_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;

    logic             done_rise;
    logic             timer_zero;

    // done_dly_q tracks the input every cycle, so a level already high when
    // S_WAIT_CFG is entered never looks like a fresh completion.
    assign done_rise  = done_cam_config & ~done_dly_q;
    assign timer_zero = (timer_q == '0);

    // ---------------------------------------------------------------------
    // Next-state / timer / retry logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;

        case (state_q)
            // S_IDLE is only ever reached through reset, so with AUTO_START
            // the sequence begins on the first cycle after reset releases.
            S_IDLE: begin
                if ((AUTO_START != 0) || init_req) begin
                    state_d = S_PWDN;
                    timer_d = PWDN_LOAD;
                    retry_d = '0;
                end
            end

            S_PWDN: begin
                if (timer_zero) begin
                    state_d = S_RESET;
                    timer_d = RST_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            S_RESET: begin
                if (timer_zero) begin
                    state_d = S_SETTLE;
                    timer_d = SETTLE_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            S_SETTLE: begin
                if (timer_zero) begin
                    state_d = S_START;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            S_START: begin
                state_d = S_WAIT_CFG;
                timer_d = CFG_LOAD;
            end

            // A rise on the final timeout cycle still counts as success.
            S_WAIT_CFG: begin
                if (done_rise) begin
                    state_d = S_READY;
                    timer_d = '0;
                end else if (timer_zero) begin
                    if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_PWDN;
                        timer_d = PWDN_LOAD;
                    end else begin
                        // retry_cnt saturates here and reports the final count.
                        state_d = S_ERROR;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            S_READY, S_ERROR: begin
                if (init_req) begin
                    state_d = S_PWDN;
                    timer_d = PWDN_LOAD;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                retry_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode of the next state; registered with the state so the
    // pins change on the same edge as the state transition.
    // ---------------------------------------------------------------------
    always_comb begin
        start_d = 1'b0;
        pwdn_d  = 1'b0;
        rstn_d  = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b0;
        error_d = 1'b0;

        case (state_d)
            S_IDLE: begin
                pwdn_d = 1'b1;
                rstn_d = 1'b0;
            end
            S_PWDN: begin
                pwdn_d = 1'b1;
                rstn_d = 1'b0;
                busy_d = 1'b1;
            end
            S_RESET: begin
                rstn_d = 1'b0;
                busy_d = 1'b1;
            end
            S_SETTLE: begin
                busy_d = 1'b1;
            end
            S_START: begin
                busy_d  = 1'b1;
                start_d = 1'b1;
            end
            S_WAIT_CFG: begin
                busy_d = 1'b1;
            end
            S_READY: begin
                ready_d = 1'b1;
            end
            // A failed camera is left powered down and held in reset.
            S_ERROR: begin
                pwdn_d  = 1'b1;
                rstn_d  = 1'b0;
                error_d = 1'b1;
            end
            default: begin
                pwdn_d = 1'b1;
                rstn_d = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            retry_q    <= '0;
            done_dly_q <= 1'b0;
            start_q    <= 1'b0;
            pwdn_q     <= 1'b1;
            rstn_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            done_dly_q <= done_cam_config;
            start_q    <= start_d;
            pwdn_q     <= pwdn_d;
            rstn_q     <= rstn_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    assign start_cam_config = start_q;
    assign cam_pwdn         = pwdn_q;
    assign cam_rstn         = rstn_q;
    assign init_busy        = busy_q;
    assign cam_ready        = ready_q;
    assign init_error       = error_q;
    assign retry_cnt        = retry_q;

endmodule

// File: tb/tb_cam_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cam_init_sequencer
//
// Directed bench for cam_init_sequencer with small timing parameters
// (PWDN=4, RST_LOW=3, SETTLE=5, CFG_TIMEOUT=20, MAX_RETRIES=2, AUTO_START=1).
// Edge numbers below count posedges after the edge that launches a sequence
// (release of reset or the init_req edge), which is edge 0. With these
// parameters: PWDN at 0..3, RESET at 4..6, SETTLE at 7..11, START at 12,
// WAIT_CFG from 13; a timeout leaves WAIT_CFG on edge 33, so each further
// attempt shifts the start pulse by 33 edges.
// ---------------------------------------------------------------------------
module tb_cam_init_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_req;
    logic       done_cam_config;
    logic       start_cam_config;
    logic       cam_pwdn;
    logic       cam_rstn;
    logic       init_busy;
    logic       cam_ready;
    logic       init_error;
    logic [3:0] retry_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Results of the most recent run_seq call
    int ns;
    int st[0:7];
    int end_c;

    cam_init_sequencer #(
        .PWDN_CYCLES   (4),
        .RST_LOW_CYCLES(3),
        .SETTLE_CYCLES (5),
        .CFG_TIMEOUT   (20),
        .MAX_RETRIES   (2),
        .AUTO_START    (1),
        .CNT_W         (23)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .init_req        (init_req),
        .done_cam_config (done_cam_config),
        .start_cam_config(start_cam_config),
        .cam_pwdn        (cam_pwdn),
        .cam_rstn        (cam_rstn),
        .init_busy       (init_busy),
        .cam_ready       (cam_ready),
        .init_error      (init_error),
        .retry_cnt       (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse init_req on one edge (edge 0 of a new sequence).
    task automatic kick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
    endtask

    // Step up to max_cyc edges, recording start pulses, until ready or error.
    // done is raised before edge done_at, dropped before edge done_lo_at, and
    // init_req is pulsed on edge req_at (-1 disables each).
    task automatic run_seq(input int max_cyc, input int done_at,
                           input int done_lo_at, input int req_at);
        ns    = 0;
        end_c = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c == done_at)    done_cam_config = 1'b1;
            if (c == done_lo_at) done_cam_config = 1'b0;
            if (c == req_at)     init_req = 1'b1;
            tick();
            init_req = 1'b0;
            if (start_cam_config && ns < 8) begin
                st[ns] = c;
                ns++;
            end
            if (cam_ready || init_error) begin
                end_c = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        init_req        = 1'b0;
        done_cam_config = 1'b0;

        // ---- 1: reset state, nominal power-up timing, first-attempt success
        tick();
        tick();
        chk("rst_pwdn",  cam_pwdn, 1);
        chk("rst_rstn",  cam_rstn, 0);
        chk("rst_start", start_cam_config, 0);
        chk("rst_busy",  init_busy, 0);
        chk("rst_ready", cam_ready, 0);
        chk("rst_error", init_error, 0);
        chk("rst_retry", retry_cnt, 0);

        rst = 1'b0;
        tick();
        chk("t1_e0_pwdn", cam_pwdn, 1);
        chk("t1_e0_rstn", cam_rstn, 0);
        chk("t1_e0_busy", init_busy, 1);
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk($sformatf("t1_e%0d_pwdn", k),  cam_pwdn, (k < 4) ? 1 : 0);
            chk($sformatf("t1_e%0d_rstn", k),  cam_rstn, (k >= 7) ? 1 : 0);
            chk($sformatf("t1_e%0d_start", k), start_cam_config, (k == 12) ? 1 : 0);
        end
        chk("t1_not_ready_yet", cam_ready, 0);
        done_cam_config = 1'b1;
        tick();
        chk("t1_ready", cam_ready, 1);
        chk("t1_busy",  init_busy, 0);
        chk("t1_retry", retry_cnt, 0);
        chk("t1_rstn",  cam_rstn, 1);
        done_cam_config = 1'b0;

        // ---- 2: done never rises -> three attempts, then error
        kick();
        chk("t2_e0_ready", cam_ready, 0);
        chk("t2_e0_busy",  init_busy, 1);
        chk("t2_e0_pwdn",  cam_pwdn, 1);
        run_seq(200, -1, -1, -1);
        chk("t2_nstart", ns, 3);
        chk("t2_start0", st[0], 12);
        chk("t2_start1", st[1], 45);
        chk("t2_start2", st[2], 78);
        chk("t2_end",    end_c, 99);
        chk("t2_error",  init_error, 1);
        chk("t2_pwdn",   cam_pwdn, 1);
        chk("t2_rstn",   cam_rstn, 0);
        chk("t2_busy",   init_busy, 0);
        chk("t2_retry",  retry_cnt, 2);

        // ---- 3: init_req out of error, success on first attempt
        kick();
        chk("t3_e0_error", init_error, 0);
        chk("t3_e0_retry", retry_cnt, 0);
        chk("t3_e0_busy",  init_busy, 1);
        run_seq(100, 18, -1, -1);
        chk("t3_start0", st[0], 12);
        chk("t3_end",    end_c, 18);
        chk("t3_ready",  cam_ready, 1);
        chk("t3_error",  init_error, 0);
        chk("t3_retry",  retry_cnt, 0);

        // ---- 4: done already high on entry to WAIT_CFG -> timeout, retry
        done_cam_config = 1'b1;
        kick();
        run_seq(200, 50, 40, -1);
        chk("t4_nstart", ns, 2);
        chk("t4_start1", st[1], 45);
        chk("t4_end",    end_c, 50);
        chk("t4_ready",  cam_ready, 1);
        chk("t4_retry",  retry_cnt, 1);

        // ---- 5: reset during SETTLE aborts and restarts cleanly
        done_cam_config = 1'b0;
        kick();
        for (int k = 1; k <= 8; k++) tick();
        chk("t5_in_settle", cam_rstn, 1);
        rst = 1'b1;
        tick();
        chk("t5_rst_pwdn",  cam_pwdn, 1);
        chk("t5_rst_rstn",  cam_rstn, 0);
        chk("t5_rst_busy",  init_busy, 0);
        chk("t5_rst_start", start_cam_config, 0);
        chk("t5_rst_retry", retry_cnt, 0);
        rst = 1'b0;
        tick();
        chk("t5_r0_busy", init_busy, 1);
        run_seq(100, 15, -1, -1);
        chk("t5_nstart", ns, 1);
        chk("t5_start0", st[0], 12);
        chk("t5_end",    end_c, 15);
        chk("t5_ready",  cam_ready, 1);

        // ---- 6: init_req in RESET ignored; rise on the exact timeout edge
        done_cam_config = 1'b0;
        kick();
        run_seq(100, 33, -1, 5);
        chk("t6_nstart", ns, 1);
        chk("t6_start0", st[0], 12);
        chk("t6_end",    end_c, 33);
        chk("t6_ready",  cam_ready, 1);
        chk("t6_retry",  retry_cnt, 0);

        // ---- 7: rst and init_req together -> rst wins
        done_cam_config = 1'b0;
        rst      = 1'b1;
        init_req = 1'b1;
        tick();
        chk("t7_busy",  init_busy, 0);
        chk("t7_ready", cam_ready, 0);
        chk("t7_pwdn",  cam_pwdn, 1);
        rst      = 1'b0;
        init_req = 1'b0;
        tick();
        chk("t7_autostart", init_busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
